// File: rtl/speed_round_ctrl.sv
// speed_round_ctrl
// Drives the push-counter interface for one speed round. The sequence is:
// countdown, the speedRound counting window, a settle delay, then a single
// sample cycle that reports the winner. An abort at any point clears the
// push counters and returns to idle without reporting a result.
module speed_round_ctrl #(
    parameter int TICK_DIV      = 50000,
    parameter int TICKS_PER_SEC = 1000,
    parameter int COUNTDOWN_T   = 3000,
    parameter int ROUND_T       = 5000,
    parameter int SETTLE_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       speed_right,
    input  logic       speed_tie,
    output logic       speedRound,
    output logic       speedExit,
    output logic       busy,
    output logic       counting_down,
    output logic [3:0] secs_left,
    output logic       done,
    output logic [1:0] result
);

    // Each counter is sized to its own largest value. The floor of 1 bit
    // keeps degenerate parameter values (for example TICK_DIV=1) legal.
    localparam int MAXT = (COUNTDOWN_T > ROUND_T) ? COUNTDOWN_T : ROUND_T;
    localparam int PW   = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
    localparam int TW   = (MAXT       > 1) ? $clog2(MAXT)       : 1;
    localparam int SW   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] CD_LAST  = TW'(COUNTDOWN_T - 1);
    localparam logic [TW-1:0] RD_LAST  = TW'(ROUND_T - 1);
    localparam logic [SW-1:0] ST_LAST  = SW'(SETTLE_CYC - 1);

    // S_ABORT is the single cycle in which speedExit clears the push
    // counters after a cancelled round.
    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_ROUND,
        S_SETTLE,
        S_SAMPLE,
        S_ABORT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PW-1:0]   r_pre;
    logic [TW-1:0]   r_tick;
    logic [SW-1:0]   r_settle;
    logic            w_tick_end;
    logic [1:0]      w_sample;
    logic [1:0]      r_result;
    logic            r_speed_round;
    logic            r_speed_exit;
    logic            r_busy;
    logic            r_counting_down;
    logic            r_done;
    logic [31:0]     w_rem;
    logic [31:0]     w_secs;

    assign w_tick_end = (r_pre == PRE_LAST);

    // The illegal input combination (right and tie both high) reports a tie.
    assign w_sample = speed_tie ? 2'b10 : (speed_right ? 2'b01 : 2'b00);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic. A timed state ends on the last prescaler cycle of
    // its final tick, so the tick counter never wraps. An abort that
    // arrives during the sample cycle is ignored, because that round has
    // already finished.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:
                if (start) w_next = S_COUNTDOWN;
            S_COUNTDOWN:
                if (abort)                                w_next = S_ABORT;
                else if (w_tick_end && r_tick == CD_LAST) w_next = S_ROUND;
            S_ROUND:
                if (abort)                                w_next = S_ABORT;
                else if (w_tick_end && r_tick == RD_LAST) w_next = S_SETTLE;
            S_SETTLE:
                if (abort)                     w_next = S_ABORT;
                else if (r_settle == ST_LAST)  w_next = S_SAMPLE;
            S_SAMPLE: w_next = S_IDLE;
            S_ABORT:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Prescaler, tick counter and settle counter. All three clear on every
    // state change, so the remaining-time count reloads when a timed state
    // is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre    <= '0;
            r_tick   <= '0;
            r_settle <= '0;
        end else if (w_next != r_state) begin
            r_pre    <= '0;
            r_tick   <= '0;
            r_settle <= '0;
        end else begin
            case (r_state)
                S_COUNTDOWN, S_ROUND: begin
                    if (w_tick_end) begin
                        r_pre  <= '0;
                        r_tick <= r_tick + 1'b1;
                    end else begin
                        r_pre  <= r_pre + 1'b1;
                    end
                end
                S_SETTLE: r_settle <= r_settle + 1'b1;
                default: ;
            endcase
        end
    end

    // The control outputs are decoded from the next state and registered,
    // so they line up with the state and speedRound cannot glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_speed_round   <= 1'b0;
            r_speed_exit    <= 1'b0;
            r_busy          <= 1'b0;
            r_counting_down <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_speed_round   <= (w_next == S_ROUND);
            r_speed_exit    <= (w_next == S_SAMPLE) || (w_next == S_ABORT);
            r_busy          <= (w_next != S_IDLE);
            r_counting_down <= (w_next == S_COUNTDOWN);
            r_done          <= (w_next == S_SAMPLE);
        end
    end

    // The result is captured at the closing edge of the sample cycle. An
    // abort never reaches this cycle, so it leaves the result unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_result <= 2'b00;
        else if (r_state == S_SAMPLE) r_result <= w_sample;
    end

    // Whole seconds remaining, rounded up and saturated to 4 bits. The
    // divisor is a parameter, so this division is by a constant.
    always_comb begin
        w_rem = 32'd0;
        case (r_state)
            S_COUNTDOWN: w_rem = 32'(COUNTDOWN_T) - 32'(r_tick);
            S_ROUND:     w_rem = 32'(ROUND_T)     - 32'(r_tick);
            default:     w_rem = 32'd0;
        endcase
        w_secs    = (w_rem + 32'(TICKS_PER_SEC) - 32'd1) / 32'(TICKS_PER_SEC);
        secs_left = (w_secs > 32'd15) ? 4'd15 : w_secs[3:0];
    end

    assign speedRound    = r_speed_round;
    assign speedExit     = r_speed_exit;
    assign busy          = r_busy;
    assign counting_down = r_counting_down;
    assign done          = r_done;
    // During the sample cycle, result already shows the value being captured.
    assign result        = (r_state == S_SAMPLE) ? w_sample : r_result;

endmodule

// File: tb/tb_speed_round_ctrl.sv
// Bench for speed_round_ctrl. A model of the round's timeline is written in
// terms of cycles since start, and the DUT is compared against it on every
// negative edge. It uses directed rounds with literal expectations and
// randomized traffic.
module tb_speed_round_ctrl;
    localparam int TD  = 2;
    localparam int TPS = 2;
    localparam int CDT = 4;
    localparam int RDT = 6;
    localparam int SC  = 4;
    localparam int CDC = CDT * TD;
    localparam int RDC = RDT * TD;
    localparam int LAT = 1 + CDC + RDC + SC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, speed_right = 1'b0, speed_tie = 1'b0;
    logic       speedRound, speedExit, busy, counting_down, done;
    logic [3:0] secs_left;
    logic [1:0] result;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    speed_round_ctrl #(
        .TICK_DIV(TD), .TICKS_PER_SEC(TPS), .COUNTDOWN_T(CDT),
        .ROUND_T(RDT), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .speed_right(speed_right), .speed_tie(speed_tie),
        .speedRound(speedRound), .speedExit(speedExit), .busy(busy),
        .counting_down(counting_down), .secs_left(secs_left),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int resf(input logic t, input logic r);
        return t ? 2 : (r ? 1 : 0);
    endfunction

    // Model: a round is "active" with m_t = cycles since the start edge.
    logic m_active, m_exit;
    int   m_t, m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0; m_exit <= 1'b0; m_t <= 0; m_res <= 0;
        end else if (m_exit) begin
            m_exit <= 1'b0;
        end else if (!m_active) begin
            if (start) begin m_active <= 1'b1; m_t <= 1; end
        end else if (m_t == LAT) begin
            m_res <= resf(speed_tie, speed_right);
            m_active <= 1'b0;
        end else if (abort) begin
            m_active <= 1'b0; m_exit <= 1'b1;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Compare every output against the model on each negative edge.
    always @(negedge clk) begin
        int e_cd, e_sr, e_done, e_exit, e_busy, rem, secs, e_res;
        e_busy = (m_active || m_exit) ? 1 : 0;
        e_cd   = (m_active && m_t <= CDC) ? 1 : 0;
        e_sr   = (m_active && m_t > CDC && m_t <= CDC + RDC) ? 1 : 0;
        e_done = (m_active && m_t == LAT) ? 1 : 0;
        e_exit = (m_exit || e_done != 0) ? 1 : 0;
        if (e_cd != 0)      rem = CDT - (m_t - 1) / TD;
        else if (e_sr != 0) rem = RDT - (m_t - 1 - CDC) / TD;
        else                rem = 0;
        secs = (rem + TPS - 1) / TPS;
        if (secs > 15) secs = 15;
        e_res = (e_done != 0) ? resf(speed_tie, speed_right) : m_res;
        chk("busy",          int'(busy),          e_busy);
        chk("counting_down", int'(counting_down), e_cd);
        chk("speedRound",    int'(speedRound),    e_sr);
        chk("done",          int'(done),          e_done);
        chk("speedExit",     int'(speedExit),     e_exit);
        chk("secs_left",     int'(secs_left),     secs);
        chk("result",        int'(result),        e_res);
    end

    task automatic tick();
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
    endtask

    // One full round, with literal expectations at the key cycles.
    task automatic run_round(input bit pre, input bit r, input bit ti,
                             input int exp_res, input bit stray, input bit chain);
        if (!pre) begin tick(); start = 1'b1; end
        speed_right = r; speed_tie = ti;
        for (int t = 1; t <= LAT; t++) begin
            tick();
            if (stray && t == 12) start = 1'b1;
            @(negedge clk);
            if (t == 1)  chk("lit_secs_t1", int'(secs_left), 2);
            if (t == 5)  chk("lit_secs_t5", int'(secs_left), 1);
            if (t == 8)  chk("lit_cd_t8", int'(counting_down), 1);
            if (t == 9)  chk("lit_secs_t9", int'(secs_left), 3);
            if (t == 9)  chk("lit_sr_t9", int'(speedRound), 1);
            if (t == 21) chk("lit_sr_t21", int'(speedRound), 0);
            if (t == LAT) begin
                chk("lit_done", int'(done), 1);
                chk("lit_exit", int'(speedExit), 1);
                chk("lit_res_done", int'(result), exp_res);
            end
        end
        tick();
        if (chain) start = 1'b1;
        @(negedge clk);
        chk("lit_res_after", int'(result), exp_res);
        chk("lit_idle_after", int'(busy), 0);
        chk("lit_secs_idle", int'(secs_left), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle for 50 cycles after reset.
        for (int i = 0; i < 50; i++) begin
            tick();
            @(negedge clk);
            if (i == 49) begin
                chk("lit_rst_busy", int'(busy), 0);
                chk("lit_rst_res", int'(result), 0);
                chk("lit_rst_sr", int'(speedRound), 0);
            end
        end

        // Directed rounds over the four input patterns, some back-to-back.
        run_round(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
        run_round(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b1);
        run_round(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_round(1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0);

        // Abort in the middle of the counting window.
        tick(); start = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 14) abort = 1'b1;
            @(negedge clk);
            if (t == 15) begin
                chk("lit_abort_sr", int'(speedRound), 0);
                chk("lit_abort_exit", int'(speedExit), 1);
                chk("lit_abort_done", int'(done), 0);
            end
            if (t == 16) begin
                chk("lit_abort_idle", int'(busy), 0);
                chk("lit_abort_res", int'(result), 2);
            end
        end

        // Reset in the middle of a round, then a clean full round.
        tick(); start = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            if (t == 10) rst = 1'b1;
            if (t == 11) rst = 1'b0;
            @(negedge clk);
            if (t == 10) begin
                chk("lit_mrst_sr", int'(speedRound), 0);
                chk("lit_mrst_busy", int'(busy), 0);
                chk("lit_mrst_exit", int'(speedExit), 0);
                chk("lit_mrst_res", int'(result), 0);
            end
        end
        run_round(1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            tick();
            start       = ($urandom % 12) == 0;
            abort       = ($urandom % 60) == 0;
            speed_right = ($urandom % 2) == 0;
            speed_tie   = ($urandom % 4) == 0;
            rst         = ($urandom % 900) == 0;
        end
        tick();
        rst = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
